// File: rtl/collect_2x1_cmd_flow_seq_if.sv
// Bundle of the two upstream flows and the merged downstream flow of the 2x1 collect node.
// Each input is taken when i_valid[k] and o_ready[k] are both high at a rising edge; the output is qualified by o_valid.
interface collect_2x1_cmd_flow_seq_if #(
   parameter int DATA_WIDTH            = 32,
   parameter int DESTINATION_TAG_WIDTH = 1,
   parameter int IN_COMMAND_WIDTH      = 1
);
   localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH;

   logic [1:0]                     i_valid;
   logic [2*DATA_WIDTH-1:0]        i_data_bus;
   logic [2*IN_COMMAND_WIDTH-1:0]  i_cmd;
   logic [1:0]                     o_ready;
   logic                           i_en;
   logic                           o_valid;
   logic [DATA_WIDTH-1:0]          o_data_bus;
   logic [OUT_COMMAND_WIDTH-1:0]   o_cmd;

   modport master (
      output i_valid, i_data_bus, i_cmd, i_en,
      input  o_ready, o_valid, o_data_bus, o_cmd
   );

   modport slave (
      input  i_valid, i_data_bus, i_cmd, i_en,
      output o_ready, o_valid, o_data_bus, o_cmd
   );
endinterface

// File: rtl/collect_2x1_cmd_flow_seq.sv
// 2-to-1 collect node: two input FIFOs drained by a round-robin arbiter into one registered output,
// prepending a source tag (1 = high, 0 = low) to the winner's command.
module collect_2x1_cmd_flow_seq #(
   parameter int DATA_WIDTH            = 32,
   parameter int DESTINATION_TAG_WIDTH = 1,
   parameter int IN_COMMAND_WIDTH      = 1,
   parameter int FIFO_DEPTH            = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   collect_2x1_cmd_flow_seq_if.slave  bus
);
   localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH;
   localparam int PW   = IN_COMMAND_WIDTH + DATA_WIDTH;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;

   logic [PW-1:0]   mem_q    [2][FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q [2];
   logic [AW-1:0]   wr_ptr_d [2];
   logic [AW-1:0]   rd_ptr_q [2];
   logic [AW-1:0]   rd_ptr_d [2];
   logic [CNTW-1:0] cnt_q    [2];
   logic [CNTW-1:0] cnt_d    [2];
   logic [PW-1:0]   entry_in [2];
   logic [PW-1:0]   head     [2];

   logic [1:0] ready;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] nempty;
   logic       sel;
   logic       do_pop;
   logic       rr_q, rr_d;

   logic                         valid_q, valid_d;
   logic [DATA_WIDTH-1:0]        data_q, data_d;
   logic [OUT_COMMAND_WIDTH-1:0] cmd_q, cmd_d;

   // Ready comes from the registered count only, so a full FIFO stays not-ready even while being popped.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         ready[k]    = cnt_q[k] < CNTW'(FIFO_DEPTH);
         push[k]     = bus.i_valid[k] & ready[k];
         nempty[k]   = cnt_q[k] != '0;
         entry_in[k] = {bus.i_cmd[k*IN_COMMAND_WIDTH +: IN_COMMAND_WIDTH],
                        bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]};
         head[k]     = mem_q[k][rd_ptr_q[k]];
      end
   end

   always_comb begin
      sel     = (nempty == 2'b11) ? rr_q : nempty[1];
      do_pop  = bus.i_en & (|nempty);
      pop     = 2'b00;
      rr_d    = rr_q;
      valid_d = valid_q;
      data_d  = data_q;
      cmd_d   = cmd_q;
      if (bus.i_en) begin
         valid_d = |nempty;
      end
      if (do_pop) begin
         pop[sel] = 1'b1;
         rr_d     = ~sel;
         data_d   = head[sel][DATA_WIDTH-1:0];
         cmd_d    = {DESTINATION_TAG_WIDTH'(sel), head[sel][PW-1:DATA_WIDTH]};
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
         rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);
         cnt_d[k]    = cnt_q[k] + CNTW'(push[k]) - CNTW'(pop[k]);
      end
   end

   // Storage is left unreset; only the pointers and counts decide what is live.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (push[k]) mem_q[k][wr_ptr_q[k]] <= entry_in[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
         rr_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cmd_q   <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
            cnt_q[k]    <= cnt_d[k];
         end
         rr_q    <= rr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
      end
   end

   assign bus.o_ready    = ready;
   assign bus.o_valid    = valid_q;
   assign bus.o_data_bus = data_q;
   assign bus.o_cmd      = cmd_q;
endmodule

// File: tb/tb_collect_2x1_cmd_flow_seq.sv
// Directed bench for collect_2x1_cmd_flow_seq: table of per-cycle vectors plus hand-written reset sequences.
module tb_collect_2x1_cmd_flow_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   collect_2x1_cmd_flow_seq_if #(
      .DATA_WIDTH(32), .DESTINATION_TAG_WIDTH(1), .IN_COMMAND_WIDTH(1)
   ) bus ();

   collect_2x1_cmd_flow_seq #(
      .DATA_WIDTH(32), .DESTINATION_TAG_WIDTH(1), .IN_COMMAND_WIDTH(1), .FIFO_DEPTH(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      logic        en;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [1:0]  cmd;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [1:0]  exp_cmd;
      logic [1:0]  exp_ready;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic add(input logic [1:0] v, input logic en, input logic [31:0] hi, input logic [31:0] lo,
                      input logic [1:0] c, input logic ev, input logic [31:0] ed, input logic [1:0] ec,
                      input logic [1:0] er);
      vec_t t;
      t.valid = v; t.en = en; t.hi = hi; t.lo = lo; t.cmd = c;
      t.exp_valid = ev; t.exp_data = ed; t.exp_cmd = ec; t.exp_ready = er;
      vecs.push_back(t);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic ev, input logic [31:0] ed,
                            input logic [1:0] ec, input logic [1:0] er);
      cmp({name, ".o_valid"},    32'(bus.o_valid),    32'(ev));
      cmp({name, ".o_data_bus"}, bus.o_data_bus,      ed);
      cmp({name, ".o_cmd"},      32'(bus.o_cmd),      32'(ec));
      cmp({name, ".o_ready"},    32'(bus.o_ready),    32'(er));
   endtask

   task automatic drive(input logic [1:0] v, input logic en, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [1:0] c);
      bus.i_valid    = v;
      bus.i_en       = en;
      bus.i_data_bus = {hi, lo};
      bus.i_cmd      = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Contention from reset: rr starts at 0 so low wins first. hi=BBBB cmd0, lo=AAAA cmd1.
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 0, 32'h0,        2'b00, 2'b11);
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 1, 32'hAAAAAAAA, 2'b01, 2'b01);
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 1, 32'hBBBBBBBB, 2'b10, 2'b10);
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 1, 32'hAAAAAAAA, 2'b01, 2'b01);
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 1, 32'hBBBBBBBB, 2'b10, 2'b10);
      add(2'b11, 1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01, 1, 32'hAAAAAAAA, 2'b01, 2'b01);
      // Drain: low holds 1, high holds 2, rr points at high.
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'hBBBBBBBB, 2'b10, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'hAAAAAAAA, 2'b01, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'hBBBBBBBB, 2'b10, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 0, 32'hBBBBBBBB, 2'b10, 2'b11);
      // Single low flow: two-edge latency, then o_valid drops.
      add(2'b01, 1, 32'h0, 32'hAAAAAAAA, 2'b01, 0, 32'hBBBBBBBB, 2'b10, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0,        2'b00, 1, 32'hAAAAAAAA, 2'b01, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0,        2'b00, 0, 32'hAAAAAAAA, 2'b01, 2'b11);
      // Backpressure: three high pushes with i_en=0, the third is dropped.
      add(2'b10, 0, 32'h11111111, 32'h0, 2'b10, 0, 32'hAAAAAAAA, 2'b01, 2'b11);
      add(2'b10, 0, 32'h22222222, 32'h0, 2'b10, 0, 32'hAAAAAAAA, 2'b01, 2'b01);
      add(2'b10, 0, 32'h33333333, 32'h0, 2'b10, 0, 32'hAAAAAAAA, 2'b01, 2'b01);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'h11111111, 2'b11, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'h22222222, 2'b11, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 0, 32'h22222222, 2'b11, 2'b11);
      // Freeze: launch low, hold it for two cycles with i_en=0, then launch high.
      add(2'b11, 1, 32'h44444444, 32'h55555555, 2'b00, 0, 32'h22222222, 2'b11, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'h55555555, 2'b00, 2'b11);
      add(2'b00, 0, 32'h0, 32'h0, 2'b00, 1, 32'h55555555, 2'b00, 2'b11);
      add(2'b00, 0, 32'h0, 32'h0, 2'b00, 1, 32'h55555555, 2'b00, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 1, 32'h44444444, 2'b10, 2'b11);
      add(2'b00, 1, 32'h0, 32'h0, 2'b00, 0, 32'h44444444, 2'b10, 2'b11);

      // Reset held two cycles with both inputs valid: nothing may be captured.
      rst = 1'b1;
      drive(2'b11, 1, 32'hDEADBEEF, 32'hCAFEF00D, 2'b11);
      repeat (2) begin
         step();
         check_all("reset", 0, 32'h0, 2'b00, 2'b11);
      end
      rst = 1'b0;
      drive(2'b00, 1, 32'h0, 32'h0, 2'b00);
      step();
      check_all("post_reset_empty", 0, 32'h0, 2'b00, 2'b11);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].valid, vecs[i].en, vecs[i].hi, vecs[i].lo, vecs[i].cmd);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                   vecs[i].exp_cmd, vecs[i].exp_ready);
      end

      // Fill both FIFOs while frozen, then reset mid-stream.
      drive(2'b11, 0, 32'h66666666, 32'h77777777, 2'b11);
      step();
      check_all("fill1", 0, 32'h44444444, 2'b10, 2'b11);
      step();
      check_all("fill2", 0, 32'h44444444, 2'b10, 2'b00);
      rst = 1'b1;
      drive(2'b00, 1, 32'h0, 32'h0, 2'b00);
      step();
      check_all("mid_reset", 0, 32'h0, 2'b00, 2'b11);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("after_reset%0d", i), 0, 32'h0, 2'b00, 2'b11);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
